memory_stage: RTL and testbench

Y86-64 SEQ memory stage, directly downstream of `execute`. It consumes `valE` together with the decoded `valA`/`valP` and selects the data-memory address and write data for the current instruction. It runs a single req/ack transaction on the data-memory port, returns `valM`, and produces the instruction status code for writeback and PC-update.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/dmem_sel.sv | 54 +++++
 rtl/memory_stage.sv | 126 ++++++++++++
 tb/tb_memory_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg: shared Y86-64 icodes, status codes and memory-stage state type.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  localparam logic [3:0] INOP    = 4'h0;
  localparam logic [3:0] IHALT   = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_sel.sv
// ---------------------------------------------------------------------------
// dmem_sel: decodes icode into data-memory address, write data, access type
// and address legality. Option: MEM_ALIGN_CHECK_EN rejects misaligned addresses.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_sel
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  output logic        rd_o,
  output logic        wr_o,
  output logic        legal_o
);

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  always_comb begin
    addr_o  = valE_i;
    wdata_o = valA_i;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    case (icode_i)
      IRMMOVQ: wr_o = 1'b1;
      IPUSHQ:  wr_o = 1'b1;
      IMRMOVQ: rd_o = 1'b1;
      ICALL: begin
        wr_o    = 1'b1;
        wdata_o = valP_i;
      end
      IRET, IPOPQ: begin
        rd_o   = 1'b1;
        addr_o = valA_i;
      end
      default: ;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    legal_o = (addr_o <= LAST_ADDR) && (addr_o[2:0] == 3'b000);
`else
    legal_o = (addr_o <= LAST_ADDR);
`endif
  end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage: Y86-64 SEQ memory stage, one req/ack data-memory transaction.
// Option: MEM_ALIGN_CHECK_EN (misaligned access -> ADR). Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_error,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        done
);

  mem_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, valm_q, valm_d;
  logic        we_q, we_d, rd_q, rd_d;
  logic [2:0]  stat_q, stat_d;

  logic [63:0] sel_addr, sel_wdata;
  logic        sel_rd, sel_wr, sel_legal, sel_access;

  dmem_sel #(.MEM_BYTES(MEM_BYTES)) u_sel (
    .icode_i (icode),
    .valE_i  (valE),
    .valA_i  (valA),
    .valP_i  (valP),
    .addr_o  (sel_addr),
    .wdata_o (sel_wdata),
    .rd_o    (sel_rd),
    .wr_o    (sel_wr),
    .legal_o (sel_legal)
  );

  assign sel_access = sel_rd | sel_wr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rd_d    = rd_q;
    valm_d  = valm_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = sel_wr;
          rd_d    = sel_rd;
          if (imem_error)                    stat_d = SADR;
          else if (!instr_valid)             stat_d = SINS;
          else if (sel_access && !sel_legal) stat_d = SADR;
          else if (icode == IHALT)           stat_d = SHLT;
          else                               stat_d = SAOK;
          // Faulted instructions skip the memory port entirely.
          if (!imem_error && instr_valid && sel_access && sel_legal)
            state_d = S_ACCESS;
          else
            state_d = S_RESP;
        end
      end
      S_ACCESS: begin
        if (dmem_ack) begin
          stat_d = dmem_error ? SADR : SAOK;
          if (rd_q && !dmem_error) valm_d = dmem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      valm_q  <= '0;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
    end
  end

  assign dmem_req   = (state_q == S_ACCESS);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign valM       = valm_q;
  assign stat       = stat_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_RESP);

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage: self-checking bench for memory_stage with a behavioural model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_stage;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valE = '0, valA = '0, valP = '0;
  logic        instr_valid = 1'b1, imem_error = 1'b0;
  logic        dmem_ack = 1'b0, dmem_error = 1'b0;
  logic [63:0] dmem_rdata = '0;
  logic        dmem_req, dmem_we, busy, done;
  logic [63:0] dmem_addr, dmem_wdata, valM;
  logic [2:0]  stat;

  int checks = 0;
  int errors = 0;

  memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error), .valM(valM), .stat(stat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Observations from the last transaction.
  logic        o_saw_req, o_we, o_stable, o_busy1;
  logic [63:0] o_addr, o_wdata;
  int          o_lat;

  // Expected results from the reference model.
  logic        e_acc, e_we;
  logic [63:0] e_addr, e_wdata;
  logic [2:0]  e_stat;
  logic [63:0] exp_valm = '0;

  // Memory semantics straight from the instruction set table.
  task automatic ref_model(input logic [3:0] ic, input logic [63:0] ve, va, vp,
                           input logic iv, ime, derr, input logic [63:0] rdata);
    logic rd, wr, legal;
    rd      = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr      = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    e_addr  = (ic == 4'h9 || ic == 4'hB) ? va : ve;
    e_wdata = (ic == 4'h8) ? vp : va;
    e_we    = wr;
    legal   = e_addr <= 64'(MEM_BYTES - 8);
`ifdef MEM_ALIGN_CHECK_EN
    if (e_addr % 8 != 0) legal = 1'b0;
`endif
    e_acc = (rd || wr) && legal && iv && !ime;
    if (ime)                    e_stat = 3'd3;
    else if (!iv)               e_stat = 3'd4;
    else if ((rd || wr) && !legal) e_stat = 3'd3;
    else if (e_acc && derr)     e_stat = 3'd3;
    else if (ic == 4'h1)        e_stat = 3'd2;
    else                        e_stat = 3'd1;
    if (e_acc && rd && !derr) exp_valm = rdata;
  endtask

  // Drives one instruction starting in the cycle after the current one and
  // plays the memory side until done or a timeout.
  task automatic do_instr(input logic [3:0] ic, input logic [63:0] ve, va, vp,
                          input logic iv, ime, input int delay, input logic derr,
                          input logic [63:0] rdata, input logic glitch);
    int  cnt;
    logic acked;
    @(posedge clk); #1;
    start = 1'b1; icode = ic; valE = ve; valA = va; valP = vp;
    instr_valid = iv; imem_error = ime;
    @(posedge clk); #1;
    start = 1'b0; instr_valid = 1'b1; imem_error = 1'b0;
    o_lat = 1; o_saw_req = 1'b0; o_stable = 1'b1; o_busy1 = busy;
    o_addr = '0; o_wdata = '0; o_we = 1'b0;
    cnt = 0; acked = 1'b0;
    while (!done && o_lat < 40) begin
      if (dmem_req) begin
        if (!o_saw_req) begin
          o_addr = dmem_addr; o_wdata = dmem_wdata; o_we = dmem_we;
        end else if (dmem_addr !== o_addr || dmem_wdata !== o_wdata || dmem_we !== o_we) begin
          o_stable = 1'b0;
        end
        o_saw_req = 1'b1;
        if (glitch && cnt == 1) begin
          start = 1'b1; icode = 4'h1; valE = ~ve; valA = ~va;
        end
        if (!acked && cnt == delay) begin
          dmem_ack = 1'b1; dmem_rdata = rdata; dmem_error = derr; acked = 1'b1;
        end
        cnt++;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_error = 1'b0; start = 1'b0;
      o_lat++;
    end
    if (!done) o_lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b we=%b busy=%b done=%b want 0 0 0 0", dmem_req, dmem_we, busy, done);
    end
    checks++;
    if (dmem_addr !== 64'h0 || dmem_wdata !== 64'h0 || valM !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h valM=%h want 0", dmem_addr, dmem_wdata, valM);
    end
    checks++;
    if (stat !== 3'd1) begin
      errors++; $display("FAIL reset_stat got %0d want 1", stat);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_push();
    do_instr(4'hA, 64'h100, 64'hDEAD, 64'h0, 1'b1, 1'b0, 2, 1'b0, 64'h0, 1'b0);
    checks++;
    if (o_saw_req !== 1'b1 || o_addr !== 64'h100 || o_we !== 1'b1 || o_wdata !== 64'hDEAD) begin
      errors++;
      $display("FAIL push_req got req=%b addr=%h we=%b wdata=%h want 1 100 1 dead", o_saw_req, o_addr, o_we, o_wdata);
    end
    checks++;
    if (o_lat !== 4) begin errors++; $display("FAIL push_latency got %0d want 4", o_lat); end
    checks++;
    if (stat !== 3'd1) begin errors++; $display("FAIL push_stat got %0d want 1", stat); end
    checks++;
    if (o_busy1 !== 1'b1) begin errors++; $display("FAIL push_busy got %b want 1", o_busy1); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL done_pulse got done=%b req=%b want 0 0", done, dmem_req);
    end
  endtask

  task automatic test_pop();
    do_instr(4'hB, 64'h777, 64'h0F8, 64'h0, 1'b1, 1'b0, 1, 1'b0, 64'h1234, 1'b0);
    checks++;
    if (o_addr !== 64'h0F8 || o_we !== 1'b0 || o_saw_req !== 1'b1) begin
      errors++; $display("FAIL pop_req got addr=%h we=%b req=%b want f8 0 1", o_addr, o_we, o_saw_req);
    end
    checks++;
    if (valM !== 64'h1234 || stat !== 3'd1 || o_lat !== 3) begin
      errors++; $display("FAIL pop_result got valM=%h stat=%0d lat=%0d want 1234 1 3", valM, stat, o_lat);
    end
    exp_valm = 64'h1234;
  endtask

  task automatic test_illegal();
    do_instr(4'h5, 64'h3F9, 64'h0, 64'h0, 1'b1, 1'b0, 0, 1'b0, 64'hBAD, 1'b0);
    checks++;
    if (o_saw_req !== 1'b0 || o_lat !== 1 || stat !== 3'd3 || valM !== 64'h1234) begin
      errors++;
      $display("FAIL illegal_addr got req=%b lat=%0d stat=%0d valM=%h want 0 1 3 1234", o_saw_req, o_lat, stat, valM);
    end
    do_instr(4'h5, 64'h3F8, 64'h0, 64'h0, 1'b1, 1'b0, 0, 1'b0, 64'h55, 1'b0);
    checks++;
    if (o_saw_req !== 1'b1 || o_lat !== 2 || stat !== 3'd1 || valM !== 64'h55) begin
      errors++;
      $display("FAIL edge_addr got req=%b lat=%0d stat=%0d valM=%h want 1 2 1 55", o_saw_req, o_lat, stat, valM);
    end
    do_instr(4'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (o_saw_req !== 1'b0 || stat !== 3'd3) begin
      errors++; $display("FAIL huge_addr got req=%b stat=%0d want 0 3", o_saw_req, stat);
    end
    exp_valm = 64'h55;
  endtask

  task automatic test_halt();
    do_instr(4'h1, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (o_lat !== 1 || stat !== 3'd2 || o_saw_req !== 1'b0) begin
      errors++; $display("FAIL halt got lat=%0d stat=%0d req=%b want 1 2 0", o_lat, stat, o_saw_req);
    end
    do_instr(4'h3, 64'h42, 64'h0, 64'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (stat !== 3'd1 || valM !== exp_valm || o_lat !== 1) begin
      errors++; $display("FAIL irmovq got stat=%0d valM=%h lat=%0d want 1 %h 1", stat, valM, o_lat, exp_valm);
    end
  endtask

  task automatic test_priority();
    do_instr(4'h5, 64'h3F9, 64'h0, 64'h0, 1'b0, 1'b1, 0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (stat !== 3'd3 || o_saw_req !== 1'b0) begin
      errors++; $display("FAIL prio_imem got stat=%0d req=%b want 3 0", stat, o_saw_req);
    end
    do_instr(4'h4, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0, 0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (stat !== 3'd4 || o_saw_req !== 1'b0 || o_lat !== 1) begin
      errors++; $display("FAIL prio_ins got stat=%0d req=%b lat=%0d want 4 0 1", stat, o_saw_req, o_lat);
    end
  endtask

  task automatic test_ignored_start();
    do_instr(4'h5, 64'h40, 64'h0, 64'h0, 1'b1, 1'b0, 3, 1'b1, 64'h9999, 1'b1);
    checks++;
    if (o_stable !== 1'b1 || o_addr !== 64'h40 || o_lat !== 5) begin
      errors++; $display("FAIL ignored_start got stable=%b addr=%h lat=%0d want 1 40 5", o_stable, o_addr, o_lat);
    end
    checks++;
    if (stat !== 3'd3 || valM !== exp_valm) begin
      errors++; $display("FAIL mem_fault got stat=%0d valM=%h want 3 %h", stat, valM, exp_valm);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_instr(4'h8, 64'h200, 64'h0, 64'hABC, 1'b1, 1'b0, 0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (o_addr !== 64'h200 || o_wdata !== 64'hABC || o_we !== 1'b1 || o_lat !== 2) begin
      errors++; $display("FAIL b2b_call got addr=%h wdata=%h we=%b lat=%0d want 200 abc 1 2", o_addr, o_wdata, o_we, o_lat);
    end
    do_instr(4'h4, 64'h208, 64'h77, 64'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (o_addr !== 64'h208 || o_wdata !== 64'h77 || o_lat !== 2 || stat !== 3'd1) begin
      errors++; $display("FAIL b2b_rmmov got addr=%h wdata=%h lat=%0d stat=%0d want 208 77 2 1", o_addr, o_wdata, o_lat, stat);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 64'({$urandom_range(0, 127), 3'b000});
      1: return 64'(MEM_BYTES - 8);
      2: return 64'(MEM_BYTES - 8 + $urandom_range(1, 40));
      3: return {$urandom, $urandom};
      default: return 64'($urandom_range(0, MEM_BYTES - 8));
    endcase
  endfunction

  task automatic test_random();
    logic [3:0]  ic;
    logic [63:0] ve, va, vp, rdata;
    logic        iv, ime, derr;
    int          dly;
    for (int i = 0; i < 60; i++) begin
      ic = 4'($urandom_range(0, 11));
      ve = rand_addr(); va = rand_addr(); vp = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      iv = ($urandom_range(0, 9) != 0); ime = ($urandom_range(0, 9) == 0);
      derr = ($urandom_range(0, 4) == 0); dly = $urandom_range(0, 3);
      ref_model(ic, ve, va, vp, iv, ime, derr, rdata);
      do_instr(ic, ve, va, vp, iv, ime, dly, derr, rdata, 1'b0);
      checks++;
      if (o_saw_req !== e_acc || o_lat !== (e_acc ? dly + 2 : 1)) begin
        errors++;
        $display("FAIL rand_access it=%0d ic=%h got req=%b lat=%0d want req=%b lat=%0d",
                 i, ic, o_saw_req, o_lat, e_acc, e_acc ? dly + 2 : 1);
      end
      if (e_acc) begin
        checks++;
        if (o_addr !== e_addr || o_we !== e_we || (e_we && o_wdata !== e_wdata) || !o_stable) begin
          errors++;
          $display("FAIL rand_port it=%0d ic=%h got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                   i, ic, o_addr, o_we, o_wdata, e_addr, e_we, e_wdata);
        end
      end
      checks++;
      if (stat !== e_stat || valM !== exp_valm) begin
        errors++;
        $display("FAIL rand_result it=%0d ic=%h got stat=%0d valM=%h want stat=%0d valM=%h",
                 i, ic, stat, valM, e_stat, exp_valm);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; icode = 4'h5; valE = 64'h80;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_pre got req=%b want 1", dmem_req); end
    #2;
    rst_n = 1'b0; dmem_ack = 1'b1; dmem_rdata = 64'hFEED;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dmem_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl got req=%b busy=%b done=%b we=%b want 0", dmem_req, busy, done, dmem_we);
    end
    checks++;
    if (dmem_addr !== 64'h0 || dmem_wdata !== 64'h0 || valM !== 64'h0 || stat !== 3'd1) begin
      errors++; $display("FAIL mid_reset_data got addr=%h wdata=%h valM=%h stat=%0d want 0 0 0 1", dmem_addr, dmem_wdata, valM, stat);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || dmem_req !== 1'b0 || valM !== 64'h0) begin
      errors++; $display("FAIL mid_after got busy=%b req=%b valM=%h want 0 0 0", busy, dmem_req, valM);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_illegal();
    test_halt();
    test_priority();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
